// File: rtl/cp0_regs_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and SR bit masks.
package cp0_regs_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] SR_IM_MASK  = 32'h0000_FC00;
  localparam logic [31:0] SR_EXL_MASK = 32'h0000_0002;
  localparam logic [31:0] SR_IE_MASK  = 32'h0000_0001;
  localparam logic [31:0] SR_WR_MASK  = SR_IM_MASK | SR_EXL_MASK | SR_IE_MASK;

  function automatic logic [4:0] excCodeOf(input logic [31:0] causeWord);
    return causeWord[6:2];
  endfunction

endpackage

// File: rtl/cp0_exc_arb.sv
// Combinational trap decision: interrupt vs. synchronous fault, and the ExcCode to record.
module cp0_exc_arb
  import cp0_regs_pkg::*;
(
  input  logic        reset,
  input  logic        validM,
  input  logic [31:0] causeIn,
  input  logic [5:0]  hwint,
  input  logic [5:0]  srIm,
  input  logic        srIe,
  input  logic        srExl,
  output logic        intReq,
  output logic        syncExc,
  output logic        excReq,
  output logic [4:0]  nextExcCode
);

  always_comb begin
    syncExc     = validM & (excCodeOf(causeIn) != EXC_INT);
    intReq      = validM & (|(hwint & srIm)) & srIe & ~srExl;
    excReq      = (syncExc | intReq) & ~reset;
    // interrupts outrank a synchronous fault on the same instruction
    nextExcCode = intReq ? EXC_INT : excCodeOf(causeIn);
  end

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file (SR/Cause/EPC/PRId) and exception-entry sequencing for the M stage.
module cp0_regs
  import cp0_regs_pkg::*;
#(
  parameter logic [31:0] PRID         = 32'h2017_1226,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic [31:0] pc_m,
  input  logic [31:0] cause_in,
  input  logic [5:0]  hwint,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        eret,
  output logic [31:0] rdata,
  output logic        exc_req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc
);

  logic [5:0]  srIm;
  logic        srExl, srIe;
  logic        causeBd;
  logic [5:0]  causeIp;
  logic [4:0]  causeExc;
  logic [31:0] epcReg;

  logic        intReq, syncExc, excReq;
  logic [4:0]  nextExcCode;

  cp0_exc_arb uArb (
    .reset      (reset),
    .validM     (valid_m),
    .causeIn    (cause_in),
    .hwint      (hwint),
    .srIm       (srIm),
    .srIe       (srIe),
    .srExl      (srExl),
    .intReq     (intReq),
    .syncExc    (syncExc),
    .excReq     (excReq),
    .nextExcCode(nextExcCode)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      srIm     <= '0;
      srExl    <= 1'b0;
      srIe     <= 1'b0;
      causeBd  <= 1'b0;
      causeIp  <= '0;
      causeExc <= '0;
      epcReg   <= '0;
    end else begin
      causeIp <= hwint;
      if (excReq) begin
        causeExc <= nextExcCode;
        // a nested fault inside the handler must not clobber the original return point
        if (!srExl) begin
          causeBd <= cause_in[31];
          epcReg  <= cause_in[31] ? pc_m - 32'd4 : pc_m;
          srExl   <= 1'b1;
        end
      end else begin
        if (we) begin
          if (addr == CP0_SR) begin
            srIm  <= wdata[15:10];
            srExl <= wdata[1];
            srIe  <= wdata[0];
          end
          if (addr == CP0_EPC) epcReg <= wdata;
        end
        if (eret) srExl <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (addr)
      CP0_SR:    rdata = {16'h0, srIm, 8'h0, srExl, srIe};
      CP0_CAUSE: rdata = {causeBd, 15'h0, causeIp, 3'h0, causeExc, 2'h0};
      CP0_EPC:   rdata = epcReg;
      CP0_PRID:  rdata = PRID;
      default:   rdata = 32'h0;
    endcase
  end

  assign exc_req    = excReq;
  assign handler_pc = HANDLER_ADDR;
  assign epc        = epcReg;

endmodule

// File: tb/tb_cp0_regs.sv
// Directed bench for cp0_regs: reset, interrupt/fault entry, nesting, eret and collisions.
module tb_cp0_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_m;
  logic [31:0] pc_m;
  logic [31:0] cause_in;
  logic [5:0]  hwint;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        eret;
  logic [31:0] rdata;
  logic        exc_req;
  logic [31:0] handler_pc;
  logic [31:0] epc;

  int checks = 0;
  int errors = 0;

  cp0_regs dut (
    .clk       (clk),
    .reset     (reset),
    .valid_m   (valid_m),
    .pc_m      (pc_m),
    .cause_in  (cause_in),
    .hwint     (hwint),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .eret      (eret),
    .rdata     (rdata),
    .exc_req   (exc_req),
    .handler_pc(handler_pc),
    .epc       (epc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; wdata = 32'h0;
  endtask

  task automatic doEret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    // reset with a would-be fault and all interrupt lines high
    reset = 1'b1; valid_m = 1'b1; pc_m = 32'h3000; cause_in = 32'h14; hwint = 6'h3f;
    we = 1'b0; addr = 5'd0; wdata = 32'h0; eret = 1'b0;
    #1;
    chk("rst_excreq0", {31'h0, exc_req}, 32'h0);
    tick();
    chk("rst_excreq1", {31'h0, exc_req}, 32'h0);
    tick();
    chk("rst_excreq2", {31'h0, exc_req}, 32'h0);
    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    rd(5'd15, 32'h2017_1226, "rst_prid");
    reset = 1'b0; valid_m = 1'b0; cause_in = 32'h0; hwint = 6'h0;
    tick();
    rd(5'd3, 32'h0, "unmapped_reg");
    chk("handler_pc", handler_pc, 32'h0000_4180);

    // SR write mask, ignored Cause write
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, 32'h0000_FC03, "sr_mask");
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 32'h0, "cause_ro");
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, 32'h0000_0401, "sr_write");

    // timer interrupt
    hwint = 6'h01; valid_m = 1'b1; pc_m = 32'h3008;
    #1;
    chk("tmr_excreq", {31'h0, exc_req}, 32'h1);
    tick();
    valid_m = 1'b0;
    rd(5'd13, 32'h0000_0400, "tmr_cause");
    rd(5'd14, 32'h3008, "tmr_epc");
    rd(5'd12, 32'h0000_0403, "tmr_sr_exl");

    // masked while EXL=1, then eret re-enables and the pending line traps
    valid_m = 1'b1; pc_m = 32'h3018;
    #1;
    chk("exl_masked", {31'h0, exc_req}, 32'h0);
    chk("eret_epc", epc, 32'h3008);
    doEret();
    rd(5'd12, 32'h0000_0401, "eret_sr");
    pc_m = 32'h3020;
    #1;
    chk("post_eret_int", {31'h0, exc_req}, 32'h1);
    tick();
    rd(5'd14, 32'h3020, "post_eret_epc");
    hwint = 6'h0; valid_m = 1'b0;
    doEret();

    // delay-slot AdES
    valid_m = 1'b1; cause_in = 32'h8000_0014; pc_m = 32'h3010;
    #1;
    chk("ades_excreq", {31'h0, exc_req}, 32'h1);
    tick();
    rd(5'd14, 32'h300c, "ades_epc");
    rd(5'd13, 32'h8000_0014, "ades_cause");

    // nested RI while EXL=1: only ExcCode changes
    cause_in = 32'h0000_0028; pc_m = 32'h3040;
    #1;
    chk("nest_excreq", {31'h0, exc_req}, 32'h1);
    tick();
    valid_m = 1'b0; cause_in = 32'h0;
    rd(5'd14, 32'h300c, "nest_epc_held");
    rd(5'd13, 32'h8000_0028, "nest_cause");
    rd(5'd12, 32'h0000_0403, "nest_sr");
    doEret();

    // bubble with everything enabled and pending
    mtc0(5'd12, 32'h0000_FC01);
    valid_m = 1'b0; hwint = 6'h3f; cause_in = 32'h14; pc_m = 32'h3044;
    #1;
    chk("bubble_excreq", {31'h0, exc_req}, 32'h0);
    tick();
    rd(5'd14, 32'h300c, "bubble_epc");
    rd(5'd13, 32'h8000_FC28, "bubble_cause_ip");

    // collision: mtc0 EPC squashed by AdEL on the same instruction
    hwint = 6'h0; valid_m = 1'b1; cause_in = 32'h10; pc_m = 32'h3050;
    we = 1'b1; addr = 5'd14; wdata = 32'h5000;
    #1;
    chk("coll_excreq", {31'h0, exc_req}, 32'h1);
    tick();
    we = 1'b0;
    rd(5'd14, 32'h3050, "coll_epc");
    rd(5'd13, 32'h0000_0010, "coll_cause");

    // eret squashed by a nested overflow
    cause_in = 32'h30; eret = 1'b1;
    tick();
    eret = 1'b0; valid_m = 1'b0; cause_in = 32'h0;
    rd(5'd12, 32'h0000_FC03, "coll_eret_sr");
    rd(5'd13, 32'h0000_0030, "coll_eret_cause");

    // we and eret together: write lands, EXL cleared
    we = 1'b1; addr = 5'd14; wdata = 32'h1234; eret = 1'b1;
    tick();
    we = 1'b0; eret = 1'b0;
    rd(5'd14, 32'h1234, "we_eret_epc");
    rd(5'd12, 32'h0000_FC01, "we_eret_sr");

    // interrupt outranks a synchronous fault
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'h01; valid_m = 1'b1; cause_in = 32'h14; pc_m = 32'h3060;
    tick();
    valid_m = 1'b0; cause_in = 32'h0;
    rd(5'd13, 32'h0000_0400, "prio_cause");
    rd(5'd14, 32'h3060, "prio_epc");

    // reset mid-trap
    hwint = 6'h0; valid_m = 1'b1; cause_in = 32'h14; pc_m = 32'h3070; reset = 1'b1;
    #1;
    chk("rst_mid_excreq", {31'h0, exc_req}, 32'h0);
    tick();
    reset = 1'b0; valid_m = 1'b0; cause_in = 32'h0;
    rd(5'd12, 32'h0, "rst_mid_sr");
    rd(5'd13, 32'h0, "rst_mid_cause");
    rd(5'd14, 32'h0, "rst_mid_epc");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
